// File: rtl/cgc_pkg.sv
// Shared types and default sizing for the per-domain clock-gating controller.
package cgc_pkg;

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_IDLE   = 2'd1,
        ST_GATED  = 2'd2,
        ST_WAKE   = 2'd3
    } cgc_state_e;

    localparam int DEF_NUM_DOMAINS = 4;
    localparam int DEF_IDLE_CYCLES = 16;
    localparam int DEF_WAKE_CYCLES = 2;
    localparam int DEF_CNT_W       = 8;

endpackage

// File: rtl/cgc_domain_fsm.sv
// Single-domain gating FSM: idle timeout, gated hold, and settle delay on wake.
// Every output is computed from the next state and then registered.
module cgc_domain_fsm
    import cgc_pkg::*;
#(
    parameter int IDLE_CYCLES = DEF_IDLE_CYCLES,
    parameter int WAKE_CYCLES = DEF_WAKE_CYCLES,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic busy,
    input  logic wake_req,
    input  logic gate_allow,
    input  logic force_on,
    output logic gate_en,
    output logic wake_ack,
    output logic gated
);

    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    cgc_state_e       state_r;
    cgc_state_e       state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             idle_q_s;
    logic             gate_en_r;
    logic             wake_ack_r;
    logic             gated_r;
    logic             gate_en_nxt_s;
    logic             wake_ack_nxt_s;
    logic             gated_nxt_s;

    // force_on and any requester activity suppress the idle qualifier, so they always beat the timeout
    assign idle_q_s = ~busy & ~wake_req & gate_allow & ~force_on;

    // State, counter and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_ACTIVE;
            cnt_r      <= CNT_ZERO;
            gate_en_r  <= 1'b1;
            wake_ack_r <= 1'b0;
            gated_r    <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            cnt_r      <= cnt_nxt_s;
            gate_en_r  <= gate_en_nxt_s;
            wake_ack_r <= wake_ack_nxt_s;
            gated_r    <= gated_nxt_s;
        end
    end

    // Next-state and counter update; WAKE runs to completion regardless of inputs
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            ST_ACTIVE: begin
                if (idle_q_s) begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    state_nxt_s = ST_ACTIVE;
                end
            end
            ST_IDLE: begin
                if (!idle_q_s) begin
                    state_nxt_s = ST_ACTIVE;
                    cnt_nxt_s   = CNT_ZERO;
                end else if (cnt_r == IDLE_LAST) begin
                    state_nxt_s = ST_GATED;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end
            ST_GATED: begin
                if (!idle_q_s) begin
                    state_nxt_s = ST_WAKE;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    state_nxt_s = ST_GATED;
                end
            end
            ST_WAKE: begin
                if (cnt_r == WAKE_LAST) begin
                    state_nxt_s = ST_ACTIVE;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_nxt_s = ST_ACTIVE;
                cnt_nxt_s   = CNT_ZERO;
            end
        endcase
    end

    // Output decode from the next state so the registered outputs change on the transition edge
    always_comb begin
        gate_en_nxt_s  = 1'b1;
        gated_nxt_s    = 1'b0;
        wake_ack_nxt_s = 1'b0;
        case (state_nxt_s)
            ST_ACTIVE: wake_ack_nxt_s = wake_req;
            ST_IDLE:   wake_ack_nxt_s = wake_req;
            ST_GATED: begin
                gate_en_nxt_s = 1'b0;
                gated_nxt_s   = 1'b1;
            end
            ST_WAKE:   wake_ack_nxt_s = 1'b0;
            default:   wake_ack_nxt_s = 1'b0;
        endcase
    end

    assign gate_en  = gate_en_r;
    assign wake_ack = wake_ack_r;
    assign gated    = gated_r;

endmodule

// File: rtl/clock_gate_ctrl.sv
// Clock-gating controller for NUM_DOMAINS independent DSP domains; drives ICG enables
// from the always-on clock. The ICG cells themselves live in the parent.
module clock_gate_ctrl
    import cgc_pkg::*;
#(
    parameter int NUM_DOMAINS = DEF_NUM_DOMAINS,
    parameter int IDLE_CYCLES = DEF_IDLE_CYCLES,
    parameter int WAKE_CYCLES = DEF_WAKE_CYCLES,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic                   clk_in,
    input  logic                   rst,
    input  logic [NUM_DOMAINS-1:0] busy,
    input  logic [NUM_DOMAINS-1:0] wake_req,
    input  logic [NUM_DOMAINS-1:0] cfg_gate_allow,
    input  logic                   force_on,
    output logic [NUM_DOMAINS-1:0] gate_en,
    output logic [NUM_DOMAINS-1:0] wake_ack,
    output logic [NUM_DOMAINS-1:0] gated
);

    for (genvar d = 0; d < NUM_DOMAINS; d++) begin : g_dom
        cgc_domain_fsm #(
            .IDLE_CYCLES (IDLE_CYCLES),
            .WAKE_CYCLES (WAKE_CYCLES),
            .CNT_W       (CNT_W)
        ) u_fsm (
            .clk        (clk_in),
            .rst        (rst),
            .busy       (busy[d]),
            .wake_req   (wake_req[d]),
            .gate_allow (cfg_gate_allow[d]),
            .force_on   (force_on),
            .gate_en    (gate_en[d]),
            .wake_ack   (wake_ack[d]),
            .gated      (gated[d])
        );
    end

endmodule

// File: tb/tb_clock_gate_ctrl.sv
// Directed bench for clock_gate_ctrl with IDLE_CYCLES=4, WAKE_CYCLES=2, four domains.
module tb_clock_gate_ctrl;

    logic       clk_in = 1'b0;
    logic       rst;
    logic [3:0] busy;
    logic [3:0] wake_req;
    logic [3:0] cfg_gate_allow;
    logic       force_on;
    logic [3:0] gate_en;
    logic [3:0] wake_ack;
    logic [3:0] gated;

    int checks = 0;
    int errors = 0;

    clock_gate_ctrl #(
        .NUM_DOMAINS (4),
        .IDLE_CYCLES (4),
        .WAKE_CYCLES (2),
        .CNT_W       (8)
    ) dut (
        .clk_in         (clk_in),
        .rst            (rst),
        .busy           (busy),
        .wake_req       (wake_req),
        .cfg_gate_allow (cfg_gate_allow),
        .force_on       (force_on),
        .gate_en        (gate_en),
        .wake_ack       (wake_ack),
        .gated          (gated)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; busy = 4'hF; wake_req = 4'h0; cfg_gate_allow = 4'hF; force_on = 1'b0;
        tick(); tick();
        chk("rst_gate_en", gate_en, 4'hF);
        chk("rst_gated", gated, 4'h0);
        chk("rst_wake_ack", wake_ack, 4'h0);

        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("busy_gate_en", gate_en, 4'hF);
            chk("busy_gated", gated, 4'h0);
        end

        // domain 0 goes idle: gates on the 5th edge
        busy = 4'hE;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("idle0_pre_gate", gate_en, 4'hF);
        end
        tick();
        chk("idle0_gate_en", gate_en, 4'hE);
        chk("idle0_gated", gated, 4'h1);

        // wake request from GATED
        wake_req = 4'h1;
        tick();
        chk("wake0_gate_en", gate_en, 4'hF);
        chk("wake0_gated", gated, 4'h0);
        chk("wake0_ack_e1", wake_ack, 4'h0);
        tick();
        chk("wake0_ack_e2", wake_ack, 4'h0);
        tick();
        chk("wake0_ack_e3", wake_ack, 4'h1);
        wake_req = 4'h0;
        tick();
        chk("wake0_ack_drop", wake_ack, 4'h0);
        busy = 4'hF;
        tick();

        // domain 1 busy returns exactly when cnt==3
        busy = 4'hD;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("race1_idle", gate_en, 4'hF);
        end
        busy = 4'hF;
        tick();
        chk("race1_no_gate", gate_en, 4'hF);
        tick();
        chk("race1_no_gate2", gate_en, 4'hF);
        busy = 4'hD;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("idle1_pre_gate", gate_en, 4'hF);
        end
        tick();
        chk("idle1_gate_en", gate_en, 4'hD);
        chk("idle1_gated", gated, 4'h2);

        // gate domains 0 and 2 while domain 1 stays gated
        busy = 4'h8;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("idle02_pre_gate", gate_en, 4'hD);
        end
        tick();
        chk("idle02_gate_en", gate_en, 4'h8);
        chk("idle02_gated", gated, 4'h7);

        // force_on wakes everything and blocks gating
        force_on = 1'b1;
        busy = 4'h0;
        tick();
        chk("force_gate_en", gate_en, 4'hF);
        chk("force_gated", gated, 4'h0);
        for (int i = 0; i < 50; i++) begin
            tick();
            chk("force_hold", gate_en, 4'hF);
        end

        // gating disallowed everywhere
        force_on = 1'b0;
        cfg_gate_allow = 4'h0;
        for (int i = 0; i < 100; i++) begin
            tick();
            chk("noallow_hold", gate_en, 4'hF);
        end

        // gate domain 3 only, then revoke permission with a wake request pending
        cfg_gate_allow = 4'h8;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("idle3_pre_gate", gate_en, 4'hF);
        end
        tick();
        chk("idle3_gate_en", gate_en, 4'h7);
        chk("idle3_gated", gated, 4'h8);
        cfg_gate_allow = 4'h0;
        wake_req = 4'h8;
        tick();
        chk("revoke3_gate_en", gate_en, 4'hF);
        chk("revoke3_gated", gated, 4'h0);
        chk("revoke3_ack_e1", wake_ack, 4'h0);
        tick();
        chk("revoke3_ack_e2", wake_ack, 4'h0);
        tick();
        chk("revoke3_ack_e3", wake_ack, 4'h8);

        // request while already ACTIVE acknowledges after one edge
        wake_req = 4'hC;
        tick();
        chk("active_ack", wake_ack, 4'hC);
        wake_req = 4'h0;
        tick();
        chk("active_ack_drop", wake_ack, 4'h0);

        // reset from mixed states
        cfg_gate_allow = 4'hF;
        for (int i = 0; i < 5; i++) begin
            tick();
        end
        chk("pre_rst_gated", gated, 4'hF);
        wake_req = 4'h3;
        rst = 1'b1;
        tick();
        chk("midrst_gate_en", gate_en, 4'hF);
        chk("midrst_gated", gated, 4'h0);
        chk("midrst_wake_ack", wake_ack, 4'h0);
        rst = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
